spi_px_master: RTL and testbench
================================

Name: spi_px_master

Overview:
- Host-side SPI initiator that drives the chip's SPI pixel slave interface (spi_cs / spi_sck / spi_sdi / spi_sdo) from an FPGA test harness or on-board stimulus generator.
- Accepts one pixel word over a valid/ready handshake and shifts it out MSB-first as one full-duplex frame.
- Simultaneously captures the word the slave returns and presents it with a one-cycle valid pulse.
- SPI mode 0: SCK idles low, data changes on falling edge, sampled on rising edge; CS active low.

Parameters:
- PX_BITS, 24: frame/word width; equals MAX_PIXEL_BITS.
- CLK_DIV, 4: clk_i cycles per SCK half-period; legal range 2..255.
- CS_GAP, 4: clk_i cycles CS stays high between frames; legal range 1..255.

Ports:
- clk_i  in  1  system clock.
- nreset_i  in  1  asynchronous active-low reset.
- tx_data_i  in  PX_BITS  word to send.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  master idle; accepts a word this cycle.
- rx_data_o  out  PX_BITS  word received in the last frame; held until the next frame completes.
- rx_valid_o  out  1  one-cycle pulse when rx_data_o updates.
- busy_o  out  1  frame or gap in progress.
- spi_cs_o  out  1  chip select, active low.
- spi_sck_o  out  1  serial clock.
- spi_sdo_o  out  1  master out, to the slave's sdi.
- spi_sdi_i  in  1  master in, from the slave's sdo; asynchronous.

Behaviour:
- Clock and reset:
  - One clock, clk_i. Reset is asynchronous and active-low on nreset_i.
  - All outputs are registered.
  - Reset values: cs=1, sck=0, sdo=0, tx_ready=1, busy=0, rx_valid=0, rx_data=0, state=IDLE.
  - Reset asserted mid-frame aborts the frame immediately: CS goes high asynchronously and no rx_valid is produced.
- spi_sdi_i passes through a 2-flop synchronizer before use.
- FSM states: IDLE, LEAD, SCK_HI, SCK_LO, TRAIL, GAP.
- IDLE:
  - tx_ready=1, cs=1, sck=0.
  - On tx_valid_i && tx_ready_o: latch tx_data_i into tx_shift, load bit_cnt=PX_BITS-1, drive sdo=tx_data_i[MSB], cs=0, go to LEAD.
- LEAD:
  - CLK_DIV cycles with cs=0, sck=0 (CS setup time).
  - Then sck=1, go to SCK_HI.
- SCK_HI:
  - CLK_DIV cycles with sck=1.
  - On the last cycle, shift synchronized sdi into rx_shift LSB.
  - Then sck=0. If bit_cnt==0, go to TRAIL. Otherwise shift tx_shift left, put the next bit on sdo, decrement bit_cnt, go to SCK_LO.
- SCK_LO:
  - CLK_DIV cycles with sck=0.
  - Then sck=1, go to SCK_HI.
- TRAIL:
  - CLK_DIV cycles with sck=0, cs=0 (CS hold time).
  - Then cs=1, sdo=0, rx_data_o<=rx_shift, rx_valid_o=1 for exactly one cycle, go to GAP.
- GAP:
  - CS_GAP cycles with cs=1.
  - Then go to IDLE with tx_ready=1.
- Frame timing:
  - Exactly PX_BITS rising SCK edges per frame.
  - CS is low for (2*PX_BITS+1)*CLK_DIV cycles.
  - Handshake to rx_valid is (2*PX_BITS+1)*CLK_DIV+1 cycles.
- Handshake rules:
  - tx_ready_o is 1 only in IDLE, so a word is accepted only there.
  - tx_valid_i asserted outside IDLE is ignored and has no side effect; the word is taken when the master returns to IDLE.
  - tx_data_i changes mid-frame have no effect.
  - Back-to-back words: next CS falls CS_GAP+1 cycles after CS rises.
- busy_o = (state != IDLE).
- Counters:
  - div_cnt is 8 bits and wraps to 0 at each phase end.
  - bit_cnt is $clog2(PX_BITS) bits.

Decomposition:
- Shared package spi_px_pkg holds:
  - the state enum typedef;
  - PX_BITS default tied to MAX_PIXEL_BITS;
  - the mode-0 CPOL/CPHA constants.
- Reuse the existing spi_dep_signal_synchronizer for spi_sdi_i.
- One natural sub-module, spi_px_clkgen: the div_cnt phase-tick generator, producing a phase_end strobe.

Test Plan:
- Reset values: hold nreset_i low, check cs=1, sck=0, tx_ready=1, rx_valid=0. Release reset, then 20 idle cycles: outputs unchanged.
- Loopback (sdo tied to sdi), CLK_DIV=2: send 0xA5C3F0.
  - Exactly 24 SCK rising edges; CS low for 98 cycles.
  - rx_data_o=0xA5C3F0 with rx_valid pulsing 1 cycle, 99 cycles after the handshake.
- Slave model returning 0x123456 while the master sends 0xFFFFFF: rx_data_o=0x123456, and the model captured 0xFFFFFF.
- Back-to-back: tx_valid held high with 0x000001 then 0x800000, CS_GAP=4.
  - Two frames, CS high for exactly 5 cycles between them.
  - Rx words arrive in order.
  - tx_ready low throughout the frames.
- Mid-frame reset: assert nreset_i after bit 10 of 0xAAAAAA.
  - cs=1 and sck=0 immediately; no rx_valid.
  - After release, a new frame with 0x555555 completes correctly.
- Ignored valid: pulse tx_valid_i with 0xDEAD00 during GAP → no new frame and no side effect.

Source files
------------

// File: rtl/spi_px_pkg.sv
// Shared types and constants for the SPI pixel master.
package spi_px_pkg;

  // Widest pixel word the slave interface carries; default frame width.
  localparam int unsigned MAX_PIXEL_BITS = 24;

  // SPI mode 0: SCK idles low, sample on rising edge, shift on falling edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_TRAIL,
    ST_GAP
  } spi_px_state_e;

endpackage

// File: rtl/spi_dep_signal_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input bit.
module spi_dep_signal_synchronizer (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Double register to resolve metastability on the incoming bit.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_px_clkgen.sv
// Phase-tick generator: strobes phase_end_o on the last cycle of each
// len_i-cycle phase while run_i is high.
module spi_px_clkgen (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       run_i,
  input  logic [7:0] len_i,
  output logic       phase_end_o
);

  logic [7:0] div_cnt_q;
  logic [7:0] div_cnt_d;

  assign phase_end_o = run_i && (div_cnt_q == (len_i - 8'd1));

  // Count within a phase; wrap to zero at phase end and park at zero when idle.
  always_comb begin
    div_cnt_d = div_cnt_q + 8'd1;
    if (!run_i || phase_end_o) begin
      div_cnt_d = '0;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/spi_px_master.sv
// SPI mode-0 initiator: sends one PX_BITS word per frame MSB-first and
// returns the word shifted in from the slave with a one-cycle valid pulse.
module spi_px_master
  import spi_px_pkg::*;
#(
  parameter int unsigned PX_BITS = MAX_PIXEL_BITS,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic [PX_BITS-1:0] tx_data_i,
  input  logic               tx_valid_i,
  output logic               tx_ready_o,
  output logic [PX_BITS-1:0] rx_data_o,
  output logic               rx_valid_o,
  output logic               busy_o,
  output logic               spi_cs_o,
  output logic               spi_sck_o,
  output logic               spi_sdo_o,
  input  logic               spi_sdi_i
);

  localparam int unsigned CW = $clog2(PX_BITS);

  spi_px_state_e      state_q, state_d;
  logic [PX_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [PX_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [PX_BITS-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic               sdo_q, sdo_d;
  logic               tx_ready_q, tx_ready_d;
  logic               busy_q, busy_d;
  logic               rx_valid_q, rx_valid_d;

  logic               sdi_sync;
  logic               phase_end;
  logic [7:0]         phase_len;

  spi_dep_signal_synchronizer u_sdi_sync (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .d_i      (spi_sdi_i),
    .q_o      (sdi_sync)
  );

  assign phase_len = (state_q == ST_GAP) ? 8'(CS_GAP) : 8'(CLK_DIV);

  spi_px_clkgen u_clkgen (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .run_i       (state_q != ST_IDLE),
    .len_i       (phase_len),
    .phase_end_o (phase_end)
  );

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    cs_d       = cs_q;
    sck_d      = sck_q;
    sdo_d      = sdo_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid_i && tx_ready_q) begin
          tx_shift_d = tx_data_i;
          bit_cnt_d  = CW'(PX_BITS - 1);
          sdo_d      = tx_data_i[PX_BITS-1];
          cs_d       = 1'b0;
          state_d    = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (phase_end) begin
          sck_d   = ~SPI_CPOL;
          state_d = ST_SCK_HI;
        end
      end
      ST_SCK_HI: begin
        if (phase_end) begin
          rx_shift_d = {rx_shift_q[PX_BITS-2:0], sdi_sync};
          sck_d      = SPI_CPOL;
          if (bit_cnt_q == '0) begin
            state_d = ST_TRAIL;
          end else begin
            tx_shift_d = {tx_shift_q[PX_BITS-2:0], 1'b0};
            sdo_d      = tx_shift_q[PX_BITS-2];
            bit_cnt_d  = bit_cnt_q - CW'(1);
            state_d    = ST_SCK_LO;
          end
        end
      end
      ST_SCK_LO: begin
        if (phase_end) begin
          sck_d   = ~SPI_CPOL;
          state_d = ST_SCK_HI;
        end
      end
      ST_TRAIL: begin
        if (phase_end) begin
          cs_d       = 1'b1;
          sdo_d      = 1'b0;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (phase_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered copies of the upcoming state.
    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any frame and raises CS at once.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      cs_q       <= 1'b1;
      sck_q      <= SPI_CPOL;
      sdo_q      <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      sdo_q      <= sdo_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign spi_cs_o   = cs_q;
  assign spi_sck_o  = sck_q;
  assign spi_sdo_o  = sdo_q;

endmodule

// File: tb/tb_spi_px_master.sv
// Directed testbench for spi_px_master with CLK_DIV=2, CS_GAP=4.
module tb_spi_px_master;

  localparam int unsigned PXB = 24;
  localparam int unsigned DIV = 2;
  localparam int unsigned GAP = 4;
  localparam logic [PXB-1:0] SLAVE_WORD = 24'h123456;

  logic           clk;
  logic           nreset;
  logic [PXB-1:0] tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [PXB-1:0] rx_data;
  logic           rx_valid;
  logic           busy;
  logic           spi_cs;
  logic           spi_sck;
  logic           spi_sdo;
  logic           spi_sdi;

  logic           loopback;
  logic           in_frame;
  logic [PXB-1:0] slave_sh;
  logic [PXB-1:0] slave_rx;

  int n_tests;
  int n_fail;

  spi_px_master #(
    .PX_BITS (PXB),
    .CLK_DIV (DIV),
    .CS_GAP  (GAP)
  ) dut (
    .clk_i      (clk),
    .nreset_i   (nreset),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .busy_o     (busy),
    .spi_cs_o   (spi_cs),
    .spi_sck_o  (spi_sck),
    .spi_sdo_o  (spi_sdo),
    .spi_sdi_i  (spi_sdi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign spi_sdi = loopback ? spi_sdo : slave_sh[PXB-1];

  // Mode-0 slave: load on CS fall, capture on SCK rise, shift on SCK fall.
  always @(spi_cs or spi_sck) begin
    if (spi_cs !== 1'b0) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      in_frame = 1'b1;
      slave_sh = SLAVE_WORD;
      slave_rx = '0;
    end else if (spi_sck) begin
      slave_rx = {slave_rx[PXB-2:0], spi_sdo};
    end else begin
      slave_sh = {slave_sh[PXB-2:0], 1'b0};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a word and return right after the handshake edge.
  task automatic send(input logic [PXB-1:0] d, input bit hold);
    int waited;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    waited   = 0;
    while (!tx_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) check("send_timeout", 32'(waited), 32'd0);
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // Follow a frame until rx_valid, measuring latency, SCK rises and CS-low cycles.
  task automatic wait_frame(output int lat, output int edges, output int cslow,
                            output logic [PXB-1:0] rx, output bit ready_bad);
    logic prev_sck;
    bit   seen;
    lat = 0; edges = 0; cslow = 0; rx = '0; ready_bad = 0; seen = 0;
    prev_sck = spi_sck;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      lat++;
      if (!spi_cs) begin
        cslow++;
        if (tx_ready) ready_bad = 1;
      end
      if (spi_sck && !prev_sck) edges++;
      prev_sck = spi_sck;
      if (rx_valid) begin
        rx   = rx_data;
        seen = 1;
        break;
      end
    end
    if (!seen) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (!tx_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 500) check("idle_timeout", 32'(waited), 32'd0);
  endtask

  initial begin
    int lat, edges, cslow, bad, gap;
    bit rbad1, rbad2;
    logic [PXB-1:0] rx1, rx2;
    logic prev;

    n_tests  = 0;
    n_fail   = 0;
    tx_valid = 1'b0;
    tx_data  = '0;
    loopback = 1'b1;
    nreset   = 1'b1;
    #1 nreset = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_sdo", 32'(spi_sdo), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_rxvalid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    nreset = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (spi_cs !== 1'b1 || spi_sck !== 1'b0 || tx_ready !== 1'b1 ||
          rx_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_stable", 32'(bad), 32'd0);

    // Loopback frame
    send(24'hA5C3F0, 0);
    wait_frame(lat, edges, cslow, rx1, rbad1);
    check("lb_latency", 32'(lat), 32'd99);
    check("lb_sck_edges", 32'(edges), 32'd24);
    check("lb_cs_low", 32'(cslow), 32'd98);
    check("lb_rxdata", 32'(rx1), 32'hA5C3F0);
    check("lb_ready_low", 32'(rbad1), 32'd0);

    // Still in GAP: rx_valid must have dropped; a valid pulse here is ignored
    @(negedge clk);
    check("lb_rxvalid_pulse", 32'(rx_valid), 32'd0);
    check("gap_busy", 32'(busy), 32'd1);
    tx_data  = 24'hDEAD00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (spi_cs !== 1'b1 || rx_valid !== 1'b0) bad++;
    end
    check("ign_no_frame", 32'(bad), 32'd0);
    check("ign_rxdata_held", 32'(rx_data), 32'hA5C3F0);
    check("ign_ready", 32'(tx_ready), 32'd1);

    // Slave model returns a distinct word
    loopback = 1'b0;
    send(24'hFFFFFF, 0);
    wait_frame(lat, edges, cslow, rx1, rbad1);
    check("sl_rxdata", 32'(rx1), 32'h123456);
    check("sl_captured", 32'(slave_rx), 32'hFFFFFF);
    check("sl_sck_edges", 32'(edges), 32'd24);
    wait_idle();

    // Back-to-back with tx_valid held
    loopback = 1'b1;
    send(24'h000001, 1);
    tx_data = 24'h800000;
    wait_frame(lat, edges, cslow, rx1, rbad1);
    gap = 0;
    while (spi_cs && gap < 100) begin
      gap++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_frame(lat, edges, cslow, rx2, rbad2);
    check("b2b_rx1", 32'(rx1), 32'h000001);
    check("b2b_rx2", 32'(rx2), 32'h800000);
    check("b2b_cs_gap", 32'(gap), 32'd5);
    check("b2b_ready_low", 32'(rbad1 | rbad2), 32'd0);
    wait_idle();

    // Mid-frame reset after the 10th SCK rise
    send(24'hAAAAAA, 0);
    edges = 0;
    prev  = spi_sck;
    for (int i = 0; i < 500 && edges < 10; i++) begin
      @(negedge clk);
      if (spi_sck && !prev) edges++;
      prev = spi_sck;
    end
    check("mr_reached_bit10", 32'(edges), 32'd10);
    #2 nreset = 1'b0;
    #1;
    check("mr_cs_async", 32'(spi_cs), 32'd1);
    check("mr_sck_async", 32'(spi_sck), 32'd0);
    check("mr_busy_async", 32'(busy), 32'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rx_valid !== 1'b0) bad++;
    end
    nreset = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (rx_valid !== 1'b0 || spi_cs !== 1'b1) bad++;
    end
    check("mr_no_rxvalid", 32'(bad), 32'd0);
    check("mr_rxdata_cleared", 32'(rx_data), 32'd0);
    send(24'h555555, 0);
    wait_frame(lat, edges, cslow, rx1, rbad1);
    check("mr_new_rxdata", 32'(rx1), 32'h555555);
    check("mr_new_latency", 32'(lat), 32'd99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
